alu_arbiter: RTL and testbench

- Shares one alu instance between two requesters, port A and port B.
- Requester A ops are issued through the ALU's A-mode (alu_enable_a); requester B ops through B-mode (alu_enable_b).
- Sequences the ALU's enable, operand and opcode pins, captures alu_out and alu_irq, and returns a one-cycle response to the granted requester.
- Sits between the two bus-side clients and alu; all ALU-side outputs are registered.

---
 rtl/alu_arbiter.sv | 107 ++++++++++
 tb/tb_alu_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between requesters A and B (round-robin, or fixed A priority with ALU_ARB_FIXED_PRIO_EN)
module alu_arbiter #(
  parameter int DW  = 8,
  parameter int OPW = 2
) (
  input  logic           alu_clk,
  input  logic           alu_rst_n,
  input  logic           a_valid,
  output logic           a_ready,
  input  logic [OPW-1:0] a_op,
  input  logic [DW-1:0]  a_in_a,
  input  logic [DW-1:0]  a_in_b,
  output logic           a_rsp_valid,
  output logic [DW-1:0]  a_rsp_data,
  output logic           a_rsp_irq,
  input  logic           b_valid,
  output logic           b_ready,
  input  logic [OPW-1:0] b_op,
  input  logic [DW-1:0]  b_in_a,
  input  logic [DW-1:0]  b_in_b,
  output logic           b_rsp_valid,
  output logic [DW-1:0]  b_rsp_data,
  output logic           b_rsp_irq,
  output logic           alu_enable,
  output logic           alu_enable_a,
  output logic           alu_enable_b,
  output logic [OPW-1:0] alu_op_a,
  output logic [OPW-1:0] alu_op_b,
  output logic [DW-1:0]  alu_in_a,
  output logic [DW-1:0]  alu_in_b,
  output logic           alu_irq_clr,
  input  logic [DW-1:0]  alu_out,
  input  logic           alu_irq,
  output logic           busy
);
  typedef enum logic [1:0] {IDLE, EXEC, CAPT, CLR} state_t;
  state_t state, state_nxt;
  logic last_b, gnt_a, gnt_b;
  // combinational arbitration; last_b doubles as the owner of the op in flight
  always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
    gnt_a = state == IDLE && a_valid;
`else
    gnt_a = state == IDLE && a_valid && (!b_valid || last_b);
`endif
    gnt_b = state == IDLE && b_valid && !gnt_a;
  end
  assign a_ready = gnt_a && alu_rst_n;
  assign b_ready = gnt_b && alu_rst_n;
  assign busy    = state != IDLE;
  // next-state: one op takes EXEC then CAPT, plus CLR when the ALU raised irq
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = (gnt_a || gnt_b) ? EXEC : IDLE;
      EXEC:    state_nxt = CAPT;
      CAPT:    state_nxt = alu_irq ? CLR : IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge alu_clk or negedge alu_rst_n)
    if (!alu_rst_n) state <= IDLE;
    else state <= state_nxt;
  // registered ALU-side pins and responses
  always_ff @(posedge alu_clk or negedge alu_rst_n) begin
    if (!alu_rst_n) begin
      last_b       <= 1'b1;
      alu_enable   <= 1'b0;
      alu_enable_a <= 1'b0;
      alu_enable_b <= 1'b0;
      alu_op_a     <= '0;
      alu_op_b     <= '0;
      alu_in_a     <= '0;
      alu_in_b     <= '0;
      alu_irq_clr  <= 1'b0;
      a_rsp_valid  <= 1'b0;
      a_rsp_data   <= '0;
      a_rsp_irq    <= 1'b0;
      b_rsp_valid  <= 1'b0;
      b_rsp_data   <= '0;
      b_rsp_irq    <= 1'b0;
    end else begin
      alu_enable   <= gnt_a || gnt_b;
      alu_enable_a <= gnt_a;
      alu_enable_b <= gnt_b;
      if (gnt_a || gnt_b) begin
        alu_in_a <= gnt_b ? b_in_a : a_in_a;
        alu_in_b <= gnt_b ? b_in_b : a_in_b;
        last_b   <= gnt_b;
      end
      if (gnt_a) alu_op_a <= a_op;
      if (gnt_b) alu_op_b <= b_op;
      a_rsp_valid <= state == CAPT && !last_b;
      b_rsp_valid <= state == CAPT && last_b;
      if (state == CAPT && !last_b) begin
        a_rsp_data <= alu_out;
        a_rsp_irq  <= alu_irq;
      end
      if (state == CAPT && last_b) begin
        b_rsp_data <= alu_out;
        b_rsp_irq  <= alu_irq;
      end
      alu_irq_clr <= state == CAPT && alu_irq;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: random and directed traffic against a cycle-timestamp transaction model
module tb_alu_arbiter;
  logic       alu_clk = 0, alu_rst_n = 0;
  logic       a_valid = 0, b_valid = 0, a_ready, b_ready;
  logic [1:0] a_op = 0, b_op = 0, alu_op_a, alu_op_b;
  logic [7:0] a_in_a = 0, a_in_b = 0, b_in_a = 0, b_in_b = 0;
  logic       a_rsp_valid, b_rsp_valid, a_rsp_irq, b_rsp_irq;
  logic [7:0] a_rsp_data, b_rsp_data, alu_in_a, alu_in_b;
  logic       alu_enable, alu_enable_a, alu_enable_b, alu_irq_clr, busy;
  logic [7:0] alu_out = 0;
  logic       alu_irq = 0, irq_req = 0, irq_lat = 0;
  int n_chk = 0, n_fail = 0;

  alu_arbiter #(.DW(8), .OPW(2)) dut (
    .alu_clk(alu_clk), .alu_rst_n(alu_rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_op(a_op), .a_in_a(a_in_a), .a_in_b(a_in_b),
    .a_rsp_valid(a_rsp_valid), .a_rsp_data(a_rsp_data), .a_rsp_irq(a_rsp_irq),
    .b_valid(b_valid), .b_ready(b_ready), .b_op(b_op), .b_in_a(b_in_a), .b_in_b(b_in_b),
    .b_rsp_valid(b_rsp_valid), .b_rsp_data(b_rsp_data), .b_rsp_irq(b_rsp_irq),
    .alu_enable(alu_enable), .alu_enable_a(alu_enable_a), .alu_enable_b(alu_enable_b),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
    .alu_irq_clr(alu_irq_clr), .alu_out(alu_out), .alu_irq(alu_irq), .busy(busy)
  );

  always #5 alu_clk = ~alu_clk;

  // behaviour of the external ALU; A-mode OP1 with b==0 holds the previous result
  function automatic logic [7:0] alu_fn(input logic mb, input logic [1:0] op, input logic [7:0] x, input logic [7:0] y, input logic [7:0] p);
    if (!mb) return op == 2'd0 ? (y == 0 ? p : x / y) : op == 2'd1 ? x + y : op == 2'd2 ? x - y : x | y;
    return op == 2'd0 ? x & y : op == 2'd1 ? x ^ y : op == 2'd2 ? 8'(x * y) : ~x;
  endfunction

  // stand-in ALU: executes when it sees a legal enable at a rising edge
  always @(posedge alu_clk) begin
    if (a_ready || b_ready) irq_lat <= irq_req;
    if (alu_enable && (alu_enable_a ^ alu_enable_b)) begin
      alu_out <= alu_fn(alu_enable_b, alu_enable_b ? alu_op_b : alu_op_a, alu_in_a, alu_in_b, alu_out);
      alu_irq <= irq_lat;
    end else if (alu_irq_clr) alu_irq <= 1'b0;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // transaction model: at most one op in flight, described by cycle timestamps
  int cyc = 0, idle_at = 0, exec_cyc = -1, rsp_cyc = -1;
  logic m_last_b = 1, t_b = 0, t_irq = 0;
  logic [1:0] t_op = 0, m_op_a = 0, m_op_b = 0;
  logic [7:0] t_ia = 0, t_ib = 0, t_res = 0, m_prev = 0, last_a = 0, last_b_data = 0;
  logic obs_ga = 0, obs_gb = 0;

  task automatic model_reset();
    idle_at = 0; exec_cyc = -1; rsp_cyc = -1; m_last_b = 1; m_op_a = 0; m_op_b = 0;
  endtask

  // one clock cycle: called just after a falling edge with this cycle's inputs already driven
  task automatic tick();
    logic ga, gb, ex, rs;
    #1;
    ex = cyc == exec_cyc;
    rs = cyc == rsp_cyc;
    check("busy", busy, cyc < idle_at);
    check("en", alu_enable, ex);
    check("en_a", alu_enable_a, ex && !t_b);
    check("en_b", alu_enable_b, ex && t_b);
    check("en_pair", alu_enable_a && alu_enable_b, 0);
    if (ex) begin
      check("in_a", alu_in_a, t_ia);
      check("in_b", alu_in_b, t_ib);
      check("op_a", alu_op_a, m_op_a);
      check("op_b", alu_op_b, m_op_b);
    end
    check("a_rsp_valid", a_rsp_valid, rs && !t_b);
    check("b_rsp_valid", b_rsp_valid, rs && t_b);
    check("irq_clr", alu_irq_clr, rs && t_irq);
    if (rs) begin
      check("rsp_data", t_b ? b_rsp_data : a_rsp_data, t_res);
      check("rsp_irq", t_b ? b_rsp_irq : a_rsp_irq, t_irq);
      m_prev = t_res;
    end
    if (a_rsp_valid) last_a = a_rsp_data;
    if (b_rsp_valid) last_b_data = b_rsp_data;
`ifdef ALU_ARB_FIXED_PRIO_EN
    ga = cyc >= idle_at && a_valid;
`else
    ga = cyc >= idle_at && a_valid && (!b_valid || m_last_b);
`endif
    gb = cyc >= idle_at && b_valid && !ga;
    check("a_ready", a_ready, ga);
    check("b_ready", b_ready, gb);
    obs_ga = a_ready;
    obs_gb = b_ready;
    if (ga || gb) begin
      t_b = gb;
      t_op = gb ? b_op : a_op;
      t_ia = gb ? b_in_a : a_in_a;
      t_ib = gb ? b_in_b : a_in_b;
      t_irq = irq_req;
      t_res = alu_fn(gb, t_op, t_ia, t_ib, m_prev);
      if (gb) m_op_b = t_op; else m_op_a = t_op;
      exec_cyc = cyc + 1;
      rsp_cyc = cyc + 3;
      idle_at = cyc + (irq_req ? 4 : 3);
      m_last_b = gb;
    end
    cyc++;
    @(negedge alu_clk);
  endtask

  task automatic run_op(input logic pb, input logic [1:0] op, input logic [7:0] x, input logic [7:0] y, input logic irq);
    logic got;
    got = 0;
    irq_req = irq;
    if (pb) begin b_valid = 1; b_op = op; b_in_a = x; b_in_b = y; end
    else begin a_valid = 1; a_op = op; a_in_a = x; a_in_b = y; end
    for (int i = 0; i < 12 && !got; i++) begin
      tick();
      got = pb ? obs_gb : obs_ga;
      if (got) begin a_valid = 0; b_valid = 0; end
    end
    a_valid = 0;
    b_valid = 0;
    irq_req = 0;
    check(pb ? "grant_b" : "grant_a", got, 1);
    repeat (5) tick();
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_outs"}, {a_ready, b_ready, alu_enable, alu_enable_a, alu_enable_b, alu_op_a, alu_op_b,
                           alu_in_a, alu_in_b, alu_irq_clr, a_rsp_valid, a_rsp_data, a_rsp_irq,
                           b_rsp_valid, b_rsp_data, b_rsp_irq}, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    logic [5:0] seq;
    int n;
    a_valid = 1; a_op = 2'd3; a_in_a = 8'h0F; a_in_b = 8'hF0;
    repeat (3) @(negedge alu_clk);
    #1 check_reset_outs("reset");
    @(negedge alu_clk);
    alu_rst_n = 1;
    run_op(0, 2'd3, 8'h0F, 8'hF0, 0);
    check("op4_or", last_a, 8'hFF);
    run_op(1, 2'd0, 8'hAA, 8'h55, 0);
    check("b_op1_and", last_b_data, 8'h00);
    a_valid = 1; b_valid = 1; a_op = 2'd1; b_op = 2'd1;
    a_in_a = 8'h11; a_in_b = 8'h22; b_in_a = 8'h33; b_in_b = 8'h44;
    seq = 0;
    n = 0;
    for (int i = 0; i < 40 && n < 6; i++) begin
      tick();
      if (obs_ga || obs_gb) begin seq[n] = obs_gb; n++; end
    end
    a_valid = 0;
    b_valid = 0;
    check("both_grants", n, 6);
`ifdef ALU_ARB_FIXED_PRIO_EN
    check("grant_seq", seq, 6'b000000);
`else
    check("grant_seq", seq, 6'b101010);
`endif
    repeat (4) tick();
    run_op(0, 2'd1, 8'h40, 8'h02, 1);
    check("irq_seen", a_rsp_irq, 1);
    a_valid = 1; b_valid = 1; irq_req = 1;
    tick();
    a_valid = 0; b_valid = 0; irq_req = 0;
    repeat (6) tick();
    run_op(0, 2'd3, 8'h3C, 8'h00, 0);
    run_op(0, 2'd0, 8'h77, 8'h00, 0);
    check("op1_hold", last_a, 8'h3C);
    a_valid = 1; a_op = 2'd1; a_in_a = 8'h05; a_in_b = 8'h06;
    n = 0;
    for (int i = 0; i < 12 && n == 0; i++) begin
      tick();
      if (obs_ga) n = 1;
    end
    check("pre_rst_grant", n, 1);
    alu_rst_n = 0;
    #1 check_reset_outs("mid_rst");
    model_reset();
    repeat (2) begin
      @(negedge alu_clk);
      #1 check("rst_no_rsp", a_rsp_valid | b_rsp_valid, 0);
    end
    @(negedge alu_clk);
    alu_rst_n = 1;
    n = 0;
    for (int i = 0; i < 12 && n == 0; i++) begin
      tick();
      if (obs_ga) begin n = 1; a_valid = 0; end
    end
    a_valid = 0;
    check("regrant_after_rst", n, 1);
    repeat (5) tick();
    for (int i = 0; i < 400; i++) begin
      if (!a_valid || obs_ga) begin
        a_valid = $urandom % 4 != 0; a_op = 2'($urandom); a_in_a = 8'($urandom); a_in_b = 8'($urandom % 3 == 0 ? 0 : $urandom);
      end
      if (!b_valid || obs_gb) begin
        b_valid = $urandom % 4 != 0; b_op = 2'($urandom); b_in_a = 8'($urandom); b_in_b = 8'($urandom);
      end
      irq_req = $urandom % 4 == 0;
      tick();
    end
    a_valid = 0;
    b_valid = 0;
    repeat (6) tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
